// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin arbiter sharing one sqrt32 core among 4 requesters
module sqrt_arbiter #(
  parameter int N = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] req_x,
  output logic [N-1:0]    ack,
  output logic            err,
  output logic [15:0]     y_out,
  output logic            busy,
  output logic [1:0]      grant_id,
  output logic            core_reset,
  output logic [31:0]     core_x,
  input  logic            core_rdy,
  input  logic [15:0]     core_y
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0]    state;
  logic [1:0]    last_grant;
  logic [1:0]    pick;
  logic [CW-1:0] cnt;
  assign busy = state != IDLE;
  assign core_reset = reset || state == LOAD;
  // round-robin pick: scan downward so the nearest requester after last_grant wins
  always_comb begin
    pick = last_grant;
    for (int i = N; i >= 1; i--)
      if (req[2'(last_grant + 2'(i))]) pick = 2'(last_grant + 2'(i));
  end
  // control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack <= '0;
      err <= 1'b0;
      y_out <= '0;
      grant_id <= '0;
      core_x <= '0;
      last_grant <= 2'd3;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          err <= 1'b0;
          cnt <= '0;
          if (|req) begin
            grant_id <= pick;
            core_x <= req_x[{pick, 5'b0} +: 32];
            state <= LOAD;
          end
        end
        LOAD: begin
          cnt <= cnt == CW'(1) ? '0 : cnt + CW'(1);
          state <= cnt == CW'(1) ? RUN : LOAD;
        end
        RUN: begin
          if (core_rdy || cnt == CW'(TIMEOUT - 1)) begin
            state <= DONE;
            if (req[grant_id]) begin
              ack <= N'(1) << grant_id;
              err <= !core_rdy;
              y_out <= core_rdy ? core_y : 16'hFFFF;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          ack <= '0;
          err <= 1'b0;
          cnt <= '0;
          last_grant <= grant_id;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed and randomized checks of sqrt_arbiter against a behavioural model
module tb_sqrt_arbiter;
  logic clk = 0, reset = 1;
  logic [3:0] req = 0;
  logic [127:0] req_x = 0;
  logic [3:0] ack;
  logic err, busy, core_reset, core_rdy;
  logic [15:0] y_out, core_y;
  logic [1:0] grant_id;
  logic [31:0] core_x;
  int checks = 0, failures = 0;
  int lat = 0;
  bit never = 0, stale = 0;
  logic rdy_q = 0;
  logic [15:0] y_q = 0;
  int ccnt = 0;

  always #5 clk = ~clk;

  sqrt_arbiter #(.N(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .ack(ack), .err(err),
    .y_out(y_out), .busy(busy), .grant_id(grant_id), .core_reset(core_reset),
    .core_x(core_x), .core_rdy(core_rdy), .core_y(core_y)
  );

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint r = 0, t;
    for (int b = 15; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return 16'(r);
  endfunction

  function automatic int rr(input int lg, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) if (r[(lg + i) % 4]) return (lg + i) % 4;
    return -1;
  endfunction

  // behavioural sqrt core: answers lat+1 cycles after leaving reset; optional stale ready during reset
  assign core_rdy = (stale && core_reset) ? 1'b1 : rdy_q;
  assign core_y = (stale && core_reset) ? 16'hBEEF : y_q;
  always @(posedge clk) begin
    if (core_reset) begin
      ccnt <= 0;
      rdy_q <= 1'b0;
    end else begin
      ccnt <= ccnt + 1;
      rdy_q <= !never && ccnt == lat;
      y_q <= isqrt(core_x);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(input int budget, output int edges);
    edges = 0;
    do begin
      tick;
      edges++;
    end while (ack == 0 && edges < budget);
  endtask

  task automatic pulse_reset;
    reset = 1;
    req = 0;
    tick;
    tick;
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) tick;
    checks++; if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (y_out !== 16'h0) begin failures++; $display("FAIL reset_y got=%h exp=0000", y_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if (core_x !== 32'h0) begin failures++; $display("FAIL reset_core_x got=%h exp=0", core_x); end
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
    reset = 0;
    tick;
  endtask

  task automatic test_basic;
    int e;
    lat = 0;
    req_x[31:0] = 144;
    req = 4'b0001;
    tick;
    checks++; if (core_reset !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_load1 core_reset=%b busy=%b exp=1,1", core_reset, busy); end
    checks++; if (grant_id !== 2'd0 || core_x !== 32'd144) begin failures++; $display("FAIL basic_grant grant=%0d core_x=%0d exp=0,144", grant_id, core_x); end
    req_x[31:0] = 999;
    tick;
    checks++; if (core_reset !== 1'b1 || core_x !== 32'd144) begin failures++; $display("FAIL basic_load2 core_reset=%b core_x=%0d exp=1,144", core_reset, core_x); end
    tick;
    checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL basic_run core_reset=%b exp=0", core_reset); end
    wait_ack(20, e);
    checks++; if (e + 3 != 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", e + 3); end
    checks++; if (ack !== 4'b0001 || y_out !== 16'd12 || err !== 1'b0) begin failures++; $display("FAIL basic_result ack=%b y=%0d err=%b exp=0001,12,0", ack, y_out, err); end
    req = 0;
    tick;
    checks++; if (ack !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_after ack=%b busy=%b exp=0000,0", ack, busy); end
  endtask

  task automatic test_round_robin;
    int e;
    logic [31:0] xs [4] = '{0, 1, 32'hFFFFFFFF, 1000000};
    logic [15:0] ys [4] = '{0, 1, 65535, 1000};
    pulse_reset;
    for (int i = 0; i < 4; i++) req_x[32*i +: 32] = xs[i];
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      lat = k;
      wait_ack(40, e);
      checks++;
      if (ack !== 4'(1 << k) || y_out !== ys[k] || err !== 1'b0) begin
        failures++;
        $display("FAIL rr_op%0d ack=%b y=%0d err=%b exp=%b,%0d,0", k, ack, y_out, err, 4'(1 << k), ys[k]);
      end
      req[k] = 1'b0;
    end
    req = 0;
    tick;
  endtask

  task automatic test_timeout;
    int e;
    never = 1;
    req_x[63:32] = 25;
    req = 4'b0010;
    wait_ack(100, e);
    checks++; if (e != 67) begin failures++; $display("FAIL timeout_latency got=%0d exp=67", e); end
    checks++; if (ack !== 4'b0010 || err !== 1'b1 || y_out !== 16'hFFFF) begin failures++; $display("FAIL timeout_result ack=%b err=%b y=%h exp=0010,1,ffff", ack, err, y_out); end
    req = 0;
    never = 0;
    tick;
    checks++; if (err !== 1'b0 || ack !== 4'b0) begin failures++; $display("FAIL timeout_clear err=%b ack=%b exp=0,0000", err, ack); end
  endtask

  task automatic test_drop;
    int e;
    lat = 10;
    req_x[95:64] = 81;
    req = 4'b0100;
    repeat (4) tick;
    req[2] = 1'b0;
    req[0] = 1'b1;
    req_x[31:0] = 16;
    for (int k = 5; k <= lat + 7; k++) begin
      tick;
      checks++; if (ack !== 4'b0 || err !== 1'b0) begin failures++; $display("FAIL drop_noack edge=%0d ack=%b err=%b exp=0000,0", k, ack, err); end
      if (k == lat + 6) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle busy=%b exp=0", busy); end
      end
      if (k == lat + 7) begin
        checks++; if (core_reset !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL drop_regrant core_reset=%b grant=%0d exp=1,0", core_reset, grant_id); end
      end
    end
    wait_ack(40, e);
    checks++; if (e != lat + 4 || ack !== 4'b0001 || y_out !== 16'd4) begin failures++; $display("FAIL drop_next edges=%0d ack=%b y=%0d exp=%0d,0001,4", e, ack, y_out, lat + 4); end
    req = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    int e;
    lat = 20;
    req_x[127:96] = 77;
    req = 4'b1000;
    repeat (6) tick;
    checks++; if (busy !== 1'b1 || core_reset !== 1'b0) begin failures++; $display("FAIL midrst_running busy=%b core_reset=%b exp=1,0", busy, core_reset); end
    reset = 1;
    tick;
    checks++; if (ack !== 4'b0 || err !== 1'b0 || y_out !== 16'h0) begin failures++; $display("FAIL midrst_outs ack=%b err=%b y=%h exp=0000,0,0000", ack, err, y_out); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || core_x !== 32'h0 || core_reset !== 1'b1) begin failures++; $display("FAIL midrst_state busy=%b grant=%0d core_x=%h core_reset=%b exp=0,0,0,1", busy, grant_id, core_x, core_reset); end
    tick;
    reset = 0;
    req = 4'b0010;
    req_x[63:32] = 49;
    lat = 2;
    wait_ack(40, e);
    checks++; if (e != 7 || ack !== 4'b0010 || y_out !== 16'd7 || err !== 1'b0) begin failures++; $display("FAIL midrst_resume edges=%0d ack=%b y=%0d err=%b exp=7,0010,7,0", e, ack, y_out, err); end
    req = 0;
    tick;
  endtask

  task automatic test_stale;
    int e;
    stale = 1;
    lat = 3;
    req_x[31:0] = 100;
    req = 4'b0001;
    wait_ack(40, e);
    checks++; if (e != 8) begin failures++; $display("FAIL stale_latency got=%0d exp=8", e); end
    checks++; if (ack !== 4'b0001 || y_out !== 16'd10) begin failures++; $display("FAIL stale_result ack=%b y=%h exp=0001,000a", ack, y_out); end
    stale = 0;
    req = 0;
    tick;
  endtask

  task automatic test_random;
    logic [31:0] xs [4];
    int lastg = 3, exp_g = -1, ops = 0, cyc = 0;
    pulse_reset;
    while (ops < 40 && cyc < 4000) begin
      tick;
      cyc++;
      if (ack != 0) begin
        checks++;
        if (exp_g < 0 || ack !== 4'(1 << exp_g) || y_out !== isqrt(xs[exp_g < 0 ? 0 : exp_g]) || err !== 1'b0) begin
          failures++;
          $display("FAIL rand_ack op=%0d ack=%b y=%0d err=%b exp_idx=%0d", ops, ack, y_out, err, exp_g);
        end
        if (exp_g >= 0) begin
          lastg = exp_g;
          req[exp_g] = 1'b0;
        end
        exp_g = -1;
        ops++;
      end else if (busy && exp_g >= 0) begin
        checks++;
        if (grant_id !== 2'(exp_g)) begin failures++; $display("FAIL rand_grant got=%0d exp=%0d", grant_id, exp_g); end
      end
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          xs[i] = $urandom;
          req_x[32*i +: 32] = xs[i];
          req[i] = 1'b1;
        end
      if (!busy && req != 0 && exp_g < 0) begin
        exp_g = rr(lastg, req);
        lat = $urandom_range(0, 6);
      end
    end
    checks++; if (ops != 40) begin failures++; $display("FAIL rand_progress ops=%0d exp=40", ops); end
    req = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_timeout;
    test_drop;
    test_reset_mid;
    test_stale;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
